// File: rtl/ser_tx_pkg.sv
// ser_tx_pkg: shared frame-width default and FSM state encoding for ser_tx
package ser_tx_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;
endpackage

// File: rtl/ser_tx_if.sv
// ser_tx_if: parallel request side, bit clock and serial frame outputs of ser_tx
interface ser_tx_if #(parameter int DATA_WIDTH = 16) ();
  logic                  bit_clk;
  logic [DATA_WIDTH-1:0] data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  cs_n;
  logic                  sclk_out;
  logic                  sdo;
  modport master (output bit_clk, data, start, input busy, done, cs_n, sclk_out, sdo);
  modport slave  (input bit_clk, data, start, output busy, done, cs_n, sclk_out, sdo);
endinterface

// File: rtl/ser_tx_edge_det.sv
// edge_det: one-register edge detector for a signal synchronous to clk_in
module edge_det (
  input  logic clk_in,
  input  logic aclr_n,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic sig_d;
  // delayed copy of sig; edges are flagged for the one cycle after sig changes
  always_ff @(posedge clk_in or negedge aclr_n) begin
    if (!aclr_n) sig_d <= 1'b0;
    else         sig_d <= sig;
  end
  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;
endmodule

// File: rtl/ser_tx.sv
// ser_tx: MSB-first serialiser paced by the divided clock bit_clk, with frame select
module ser_tx
  import ser_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic     clk_in,
  input logic     aclr_n,
  ser_tx_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;
  logic                  rise, fall;
  logic                  busy_r, done_r, cs_n_r, sclk_r, sdo_r;
  edge_det u_edge (
    .clk_in (clk_in),
    .aclr_n (aclr_n),
    .sig    (bus.bit_clk),
    .rise   (rise),
    .fall   (fall)
  );
  // frame sequencer: sdo moves on bit_clk falls, bits are counted on rises
  always_ff @(posedge clk_in or negedge aclr_n) begin
    if (!aclr_n) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cs_n_r <= 1'b1;
      sclk_r <= 1'b0;
      sdo_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      sclk_r <= (state == SHIFT || state == HOLD) ? bus.bit_clk : 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sreg   <= bus.data;
          sdo_r  <= bus.data[DATA_WIDTH-1];
          cs_n_r <= 1'b0;
          busy_r <= 1'b1;
          cnt    <= '0;
          state  <= SETUP;
        end
        SETUP: if (fall) state <= SHIFT;
        SHIFT: begin
          if (rise) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DATA_WIDTH - 1)) state <= HOLD;
          end
          if (fall) begin
            sreg  <= sreg << 1;
            sdo_r <= sreg[DATA_WIDTH-2];
          end
        end
        HOLD: if (fall) begin
          cs_n_r <= 1'b1;
          sdo_r  <= 1'b0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.cs_n     = cs_n_r;
  assign bus.sclk_out = sclk_r;
  assign bus.sdo      = sdo_r;
endmodule

// File: tb/tb_ser_tx.sv
// tb_ser_tx: scoreboard bench for ser_tx at 16 and 8 bit frame widths
`timescale 1ns/1ps
module tb_ser_tx;
  logic clk_in = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic bclk = 1'b0;
  logic stuck = 1'b0;
  logic [1:0] dc = '0;
  int checks = 0;
  int errors = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] sh_a = '0, sh_b = '0;
  int nb_a = 0, nb_b = 0, dn_a = 0, dn_b = 0;
  logic ps_a = 1'b0, ps_b = 1'b0;
  ser_tx_if #(.DATA_WIDTH(16)) ifa ();
  ser_tx_if #(.DATA_WIDTH(8))  ifb ();
  assign ifa.bit_clk = bclk;
  assign ifb.bit_clk = bclk;
  ser_tx #(.DATA_WIDTH(16)) dut_a (.clk_in(clk_in), .aclr_n(rst_a), .bus(ifa.slave));
  ser_tx #(.DATA_WIDTH(8))  dut_b (.clk_in(clk_in), .aclr_n(rst_b), .bus(ifb.slave));
  always #250 clk_in = ~clk_in;
  // upstream clk_div model: bit_clk period of 8 clk_in cycles, can be frozen low
  always @(posedge clk_in) begin
    if (stuck) begin
      bclk <= 1'b0;
      dc   <= '0;
    end else begin
      dc <= dc + 2'd1;
      if (dc == 2'd3) bclk <= ~bclk;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // receiver A: sample sdo at each sclk_out rise, score the word at done
  always @(negedge clk_in) begin
    if (!rst_a) begin
      nb_a = 0;
      sh_a = '0;
    end else begin
      if (ifa.sclk_out && !ps_a) begin
        check("cs_n_low_at_sclk_a", 32'(ifa.cs_n), 32'd0);
        sh_a = {sh_a[30:0], ifa.sdo};
        nb_a++;
      end
      if (ifa.done) begin
        dn_a++;
        check("done_expected_a", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          check("word_a", sh_a, q_a.pop_front());
          check("bits_a", nb_a, 32'd16);
        end
        nb_a = 0;
        sh_a = '0;
      end
    end
    ps_a = ifa.sclk_out;
  end
  // receiver B: same as A for the 8-bit instance
  always @(negedge clk_in) begin
    if (!rst_b) begin
      nb_b = 0;
      sh_b = '0;
    end else begin
      if (ifb.sclk_out && !ps_b) begin
        sh_b = {sh_b[30:0], ifb.sdo};
        nb_b++;
      end
      if (ifb.done) begin
        dn_b++;
        check("done_expected_b", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          check("word_b", sh_b, q_b.pop_front());
          check("bits_b", nb_b, 32'd8);
        end
        nb_b = 0;
        sh_b = '0;
      end
    end
    ps_b = ifb.sclk_out;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic send_a(input logic [15:0] d);
    ifa.data  = d;
    ifa.start = 1'b1;
    q_a.push_back(32'(d));
    @(negedge clk_in);
    ifa.start = 1'b0;
  endtask
  task automatic wait_done_a(input string tag);
    for (int k = 0; k < 400 && !ifa.done; k++) @(negedge clk_in);
    check(tag, 32'(ifa.done), 32'd1);
    @(negedge clk_in);
  endtask
  task automatic wait_bits_a(input int n);
    for (int k = 0; k < 400 && nb_a < n; k++) @(negedge clk_in);
    check("reach_bit_a", 32'(nb_a >= n), 32'd1);
  endtask
  initial begin
    ifa.start = 1'b0;
    ifa.data  = '0;
    ifb.start = 1'b0;
    ifb.data  = '0;
    cyc(4);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_done", 32'(ifa.done), 32'd0);
    check("rst_cs_n", 32'(ifa.cs_n), 32'd1);
    check("rst_sclk", 32'(ifa.sclk_out), 32'd0);
    check("rst_sdo", 32'(ifa.sdo), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    cyc(3);
    send_a(16'hA5C3);
    check("start_cs_n", 32'(ifa.cs_n), 32'd0);
    check("start_busy", 32'(ifa.busy), 32'd1);
    check("start_sdo_msb", 32'(ifa.sdo), 32'd1);
    wait_done_a("done_frame1");
    check("done_count1", dn_a, 32'd1);
    check("idle_busy1", 32'(ifa.busy), 32'd0);
    cyc(5);
    send_a(16'hA5C3);
    wait_bits_a(5);
    ifa.data  = 16'hFFFF;
    ifa.start = 1'b1;
    @(negedge clk_in);
    ifa.start = 1'b0;
    wait_done_a("done_frame2");
    cyc(150);
    check("no_extra_frame", dn_a, 32'd2);
    check("idle_busy2", 32'(ifa.busy), 32'd0);
    send_a(16'h1234);
    wait_bits_a(7);
    rst_a = 1'b0;
    #1;
    check("abort_cs_n", 32'(ifa.cs_n), 32'd1);
    check("abort_sclk", 32'(ifa.sclk_out), 32'd0);
    check("abort_sdo", 32'(ifa.sdo), 32'd0);
    check("abort_busy", 32'(ifa.busy), 32'd0);
    void'(q_a.pop_back());
    cyc(3);
    rst_a = 1'b1;
    cyc(20);
    check("abort_no_done", dn_a, 32'd2);
    send_a(16'h0001);
    wait_done_a("done_after_reset");
    cyc(4);
    send_a(16'h1357);
    for (int k = 0; k < 400 && !ifa.done; k++) @(negedge clk_in);
    check("b2b_first_done", 32'(ifa.done), 32'd1);
    check("b2b_gap_cs_n", 32'(ifa.cs_n), 32'd1);
    send_a(16'h8000);
    check("b2b_cs_n", 32'(ifa.cs_n), 32'd0);
    check("b2b_busy", 32'(ifa.busy), 32'd1);
    wait_done_a("done_b2b");
    check("done_count_b2b", dn_a, 32'd5);
    stuck = 1'b1;
    cyc(10);
    send_a(16'h00FF);
    cyc(200);
    check("stuck_busy", 32'(ifa.busy), 32'd1);
    check("stuck_cs_n", 32'(ifa.cs_n), 32'd0);
    check("stuck_sclk", 32'(ifa.sclk_out), 32'd0);
    check("stuck_no_done", dn_a, 32'd5);
    rst_a = 1'b0;
    void'(q_a.pop_back());
    cyc(2);
    rst_a = 1'b1;
    stuck = 1'b0;
    cyc(4);
    ifb.data  = 8'h3C;
    ifb.start = 1'b1;
    q_b.push_back(32'h3C);
    @(negedge clk_in);
    ifb.start = 1'b0;
    for (int k = 0; k < 300 && !ifb.done; k++) @(negedge clk_in);
    check("done_w8", 32'(ifb.done), 32'd1);
    cyc(2);
    check("done_count_w8", dn_b, 32'd1);
    check("queue_a_empty", q_a.size(), 32'd0);
    check("queue_b_empty", q_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
- REQ-001 Parameter DATA_WIDTH, default 16: frame length in bits; legal range 2..32.
- REQ-002 clk_in  input  1  system clock; also clocks the upstream clk_div, so bit_clk is synchronous to it.
- REQ-003 aclr_n  input  1  reset; asynchronous, active-low.
- REQ-004 bit_clk  input  1  divided clock from clk_div; sampled as data, never used as a clock.
- REQ-005 data  input  DATA_WIDTH  parallel word; sampled only when a start is accepted.
- REQ-006 start  input  1  single-cycle request to transmit data.
- REQ-007 busy  output  1  high while a frame is in progress.
- REQ-008 done  output  1  single-cycle pulse at the end of a frame.
- REQ-009 cs_n  output  1  frame select, active-low.
- REQ-010 sclk_out  output  1  serial clock, gated copy of bit_clk.
- REQ-011 sdo  output  1  serial data, MSB first.

Function
- REQ-012 All outputs SHALL be registered on clk_in.
- REQ-013 bit_clk SHALL be registered once (bit_clk_d). Edge flags: rise = bit_clk & ~bit_clk_d; fall = ~bit_clk & bit_clk_d. Outputs react one clk_in cycle after a bit_clk transition.
- REQ-014 The FSM SHALL have exactly four states: IDLE, SETUP, SHIFT, HOLD.
- REQ-015 IDLE: start=1 SHALL be accepted. On acceptance: data -> shift register, sdo <= data[MSB], cs_n <= 0, busy <= 1, bit counter <= 0, next state SETUP.
- REQ-016 SETUP: the FSM SHALL wait for fall and then enter SHIFT; sclk_out SHALL stay 0.
- REQ-017 SHIFT: each rise SHALL increment the bit counter.
  - On a rise when the counter is DATA_WIDTH-1, the FSM SHALL enter HOLD.
  - Each fall SHALL shift the register left and drive the next bit on sdo.
- REQ-018 HOLD: on fall, the block SHALL drive cs_n <= 1, sdo <= 0, busy <= 0, done <= 1 for one cycle, and return to IDLE.
- REQ-019 sclk_out SHALL follow bit_clk (registered) in SHIFT and HOLD, and be 0 in every other state. Exactly DATA_WIDTH rising edges per frame.
- REQ-020 sdo SHALL change only on fall (data stable at every sclk_out rise), except at frame start (REQ-015) and frame end (REQ-018).
- REQ-021 start while busy=1 SHALL be ignored; data is not resampled.
- REQ-022 In the done cycle busy=0 and the state is IDLE, so a start in that cycle SHALL be accepted (back-to-back frames).
- REQ-023 bit_clk stuck at either level SHALL leave the FSM waiting indefinitely with busy=1 (no timeout).
- REQ-024 rise and fall SHALL be mutually exclusive; no simultaneous-edge handling is required.

Reset
- REQ-025 aclr_n=0 SHALL immediately force:
  - FSM state: IDLE
  - busy=0, done=0, cs_n=1, sclk_out=0, sdo=0
  - shift register=0, bit counter=0, bit_clk_d=0
- REQ-026 Reset asserted mid-frame SHALL abort the frame without a done pulse. The first start after release SHALL begin a clean frame.

Structure
- REQ-027 A shared package SHALL hold the state encoding constants and the DATA_WIDTH default.
- REQ-028 Bit-counter width SHALL be $clog2(DATA_WIDTH+1).
- REQ-029 Edge detection SHALL be a sub-module edge_det (ports: clk_in, aclr_n, sig, rise, fall), instanced once for bit_clk.

Verification
All scenarios use clk_in 2 MHz and bit_clk from clk_div 2 MHz/250 kHz (period 8 clk_in cycles).
- REQ-030 Frame: start with data=16'hA5C3 -> sdo sampled at 16 sclk_out rises = 1010_0101_1100_0011; cs_n low for the whole frame; exactly one done pulse.
- REQ-031 Ignored start: second start with data=16'hFFFF during bit 5 -> transmitted word unchanged (A5C3); no extra frame.
- REQ-032 Reset mid-frame: aclr_n low at bit 7 -> same cycle cs_n=1, sclk_out=0, sdo=0, busy=0; no done. After release, start with 16'h0001 -> correct frame.
- REQ-033 Back-to-back: start held for the done cycle with 16'h8000 -> new frame begins; cs_n stays high at least one cycle between frames.
- REQ-034 DATA_WIDTH=8, data=8'h3C -> 8 sclk_out rises, sdo 0011_1100.
- REQ-035 Stuck bit_clk: bit_clk held 0 after start -> busy=1, cs_n=0, sclk_out=0 indefinitely; no done.
